// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode, ALU and mux-select encodings for multicycle_controller
package mc_pkg;

    typedef enum logic [3:0] {
        S_WAKE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTER = 4'd7,
        S_EXECUTEI = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALUOp plus funct3/funct7b5 to the ALU operation code
module alu_decoder
    import mc_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    input  logic [1:0] alu_op,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type from I-type so addi never becomes sub
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RISC-V control FSM with memory wait timeout
// Optional feature: MC_ILLEGAL_TRAP_EN sends unknown opcodes to a reset-only TRAP state.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       mem_err,
    output logic [3:0] state_dbg
);

    state_t     state, state_next;
    logic [7:0] wait_cnt;
    logic       armed;
    logic [1:0] alu_op;
    logic       mem_state;
    logic       timeout;

    assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timeout   = mem_state && !mem_ready && (wait_cnt == 8'(TIMEOUT - 1));

    // armed holds WAKE for one extra edge so the first FETCH lands two edges after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_WAKE;
            wait_cnt <= 8'd0;
            armed    <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
            if (!mem_state || timeout || (state_next != state)) begin
                wait_cnt <= 8'd0;
            end else if (!mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        alu_op     = ALUOP_ADD;
        mem_req    = 1'b0;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        mem_err    = 1'b0;
        case (state)
            S_WAKE: begin
                if (armed) state_next = S_FETCH;
            end
            S_FETCH: begin
                ResultSrc = RES_ALURESULT;
                ALUSrcB   = SRCB_FOUR;
                mem_req   = !timeout;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout) begin
                    mem_err = 1'b1;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (Opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTER;
                    OP_ITYPE:     state_next = S_EXECUTEI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        state_next = S_TRAP;
`else
                        instr_done = 1'b1;
                        state_next = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                state_next = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                mem_req = !timeout;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (timeout) begin
                    mem_err    = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                mem_req  = !timeout;
                MemWrite = !timeout;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end else if (timeout) begin
                    mem_err    = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXECUTER: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                alu_op     = ALUOP_SUB;
                PCWrite    = Zero;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP: state_next = S_TRAP;
`endif
            default: state_next = S_WAKE;
        endcase
    end

    // ImmSrc follows Opcode everywhere except the reset/wake state, which keeps every output low
    assign ImmSrc    = (state == S_WAKE) ? IMM_I : imm_src_of(Opcode);
    assign state_dbg = state;

    alu_decoder u_alu_decoder (
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (Opcode[5]),
        .alu_op      (alu_op),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller (TIMEOUT=4)
module tb_multicycle_controller;

    localparam logic [3:0] ST_WAKE = 4'd0,  ST_FETCH = 4'd1,  ST_DECODE = 4'd2,  ST_MEMADR = 4'd3;
    localparam logic [3:0] ST_MEMREAD = 4'd4, ST_MEMWB = 4'd5, ST_MEMWRITE = 4'd6, ST_EXR = 4'd7;
    localparam logic [3:0] ST_EXI = 4'd8, ST_ALUWB = 4'd9, ST_BEQ = 4'd10, ST_JAL = 4'd11, ST_TRAP = 4'd12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] Opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, mem_err;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_dbg;
    logic [6:0] strb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // strobe order: mem_req PCWrite MemWrite IRWrite RegWrite instr_done mem_err
    assign strb = {mem_req, PCWrite, MemWrite, IRWrite, RegWrite, instr_done, mem_err};

    multicycle_controller #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Opcode     (Opcode),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .instr_done (instr_done),
        .mem_err    (mem_err),
        .state_dbg  (state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [3:0] st, input logic [6:0] sb);
        #1;
        chk({tag, ".state"}, 32'(state_dbg), 32'(st));
        chk({tag, ".strb"}, 32'(strb), 32'(sb));
    endtask

    task automatic do_fetch(input string tag);
        mem_ready = 1'b1;
        cyc({tag, ".fetch"}, ST_FETCH, 7'b1101000);
        chk({tag, ".fetch_mux"}, 32'({ResultSrc, ALUSrcB, AdrSrc, ALUSrcA, ALUControl}), 32'({2'b10, 2'b10, 1'b0, 2'b00, 3'b000}));
        tick();
        cyc({tag, ".decode"}, ST_DECODE, 7'b0000000);
        chk({tag, ".decode_mux"}, 32'({ALUSrcA, ALUSrcB, ALUControl}), 32'({2'b01, 2'b01, 3'b000}));
    endtask

    task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [3:0] exp_st, input logic [1:0] exp_srcb, input logic [2:0] exp_alu);
        Opcode = op; funct3 = f3; funct7b5 = f7;
        do_fetch(tag);
        tick();
        cyc({tag, ".exec"}, exp_st, 7'b0000000);
        chk({tag, ".exec_mux"}, 32'({ALUSrcA, ALUSrcB, ALUControl}), 32'({2'b10, exp_srcb, exp_alu}));
        tick();
        cyc({tag, ".aluwb"}, ST_ALUWB, 7'b0000110);
        chk({tag, ".aluwb_res"}, 32'(ResultSrc), 32'(2'b00));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; Opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc("rst", ST_WAKE, 7'b0000000);
        chk("rst.mux", 32'({ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, AdrSrc}), 32'd0);
        rst_n = 1'b1;
        cyc("wake0", ST_WAKE, 7'b0000000);
        tick();
        cyc("wake1", ST_WAKE, 7'b0000000);
        tick();

        run_alu("add",  7'b0110011, 3'b000, 1'b0, ST_EXR, 2'b00, 3'b000);
        run_alu("sub",  7'b0110011, 3'b000, 1'b1, ST_EXR, 2'b00, 3'b001);
        run_alu("addi", 7'b0010011, 3'b000, 1'b1, ST_EXI, 2'b01, 3'b000);
        run_alu("slt",  7'b0110011, 3'b010, 1'b0, ST_EXR, 2'b00, 3'b101);
        run_alu("ori",  7'b0010011, 3'b110, 1'b0, ST_EXI, 2'b01, 3'b011);
        run_alu("and",  7'b0110011, 3'b111, 1'b0, ST_EXR, 2'b00, 3'b010);
        run_alu("xor",  7'b0110011, 3'b100, 1'b0, ST_EXR, 2'b00, 3'b000);

        // lw: mem_ready arrives in the 4th MEMREAD cycle, which is also the timeout cycle
        Opcode = 7'b0000011; funct3 = 3'b010;
        do_fetch("lw");
        chk("lw.imm", 32'(ImmSrc), 32'(2'b00));
        tick();
        cyc("lw.memadr", ST_MEMADR, 7'b0000000);
        chk("lw.memadr_mux", 32'({ALUSrcA, ALUSrcB, ALUControl}), 32'({2'b10, 2'b01, 3'b000}));
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("lw.wait", ST_MEMREAD, 7'b1000000);
            chk("lw.wait_mux", 32'({AdrSrc, ResultSrc}), 32'({1'b1, 2'b00}));
            tick();
        end
        mem_ready = 1'b1;
        cyc("lw.ready", ST_MEMREAD, 7'b1000000);
        tick();
        cyc("lw.memwb", ST_MEMWB, 7'b0000110);
        chk("lw.memwb_res", 32'(ResultSrc), 32'(2'b01));
        tick();

        Opcode = 7'b0100011;
        do_fetch("sw");
        chk("sw.imm", 32'(ImmSrc), 32'(2'b01));
        tick();
        tick();
        mem_ready = 1'b0;
        cyc("sw.wait", ST_MEMWRITE, 7'b1010000);
        chk("sw.adr", 32'(AdrSrc), 32'(1'b1));
        tick();
        mem_ready = 1'b1;
        cyc("sw.done", ST_MEMWRITE, 7'b1010010);
        tick();

        Opcode = 7'b1100011; Zero = 1'b1;
        do_fetch("beq1");
        chk("beq1.imm", 32'(ImmSrc), 32'(2'b10));
        tick();
        cyc("beq1.beq", ST_BEQ, 7'b0100010);
        chk("beq1.alu", 32'({ALUSrcA, ALUSrcB, ALUControl}), 32'({2'b10, 2'b00, 3'b001}));
        tick();
        Zero = 1'b0;
        do_fetch("beq0");
        tick();
        cyc("beq0.beq", ST_BEQ, 7'b0000010);
        tick();

        Opcode = 7'b1101111;
        do_fetch("jal");
        chk("jal.imm", 32'(ImmSrc), 32'(2'b11));
        tick();
        cyc("jal.jal", ST_JAL, 7'b0100000);
        chk("jal.mux", 32'({ALUSrcA, ALUSrcB, ALUControl, ResultSrc}), 32'({2'b01, 2'b10, 3'b000, 2'b00}));
        tick();
        cyc("jal.aluwb", ST_ALUWB, 7'b0000110);
        tick();

        // fetch timeout: three waiting cycles, error on the 4th, then a clean retry
        Opcode = 7'b0110011; funct3 = 3'b000; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("fto.wait", ST_FETCH, 7'b1000000);
            tick();
        end
        cyc("fto.err", ST_FETCH, 7'b0000001);
        tick();
        cyc("fto.retry", ST_FETCH, 7'b1000000);

        // store timeout: no write strobe in the error cycle
        Opcode = 7'b0100011;
        do_fetch("swto");
        tick();
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("swto.wait", ST_MEMWRITE, 7'b1010000);
            tick();
        end
        cyc("swto.err", ST_MEMWRITE, 7'b0000001);
        tick();
        cyc("swto.back", ST_FETCH, 7'b1000000);

        Opcode = 7'b1111111;
`ifdef MC_ILLEGAL_TRAP_EN
        do_fetch("ill");
        tick();
        for (int i = 0; i < 3; i++) begin
            cyc("ill.trap", ST_TRAP, 7'b0000000);
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
`else
        mem_ready = 1'b1;
        cyc("ill.fetch", ST_FETCH, 7'b1101000);
        tick();
        cyc("ill.nop", ST_DECODE, 7'b0000010);
        tick();
`endif

        // reset in the middle of a store
        Opcode = 7'b0100011;
        do_fetch("rmw");
        tick();
        tick();
        mem_ready = 1'b0;
        cyc("rmw.wait", ST_MEMWRITE, 7'b1010000);
        #2;
        rst_n = 1'b0;
        cyc("rmw.rst", ST_WAKE, 7'b0000000);
        tick();
        rst_n = 1'b1;
        cyc("rmw.wake0", ST_WAKE, 7'b0000000);
        tick();
        cyc("rmw.wake1", ST_WAKE, 7'b0000000);
        tick();
        cyc("rmw.fetch", ST_FETCH, 7'b1000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
